// File: rtl/fifo_pkg.sv
// Shared helpers for the multi-write FWFT FIFO: sizing, lane counting and the empty-slot value.
// Elements and lane vectors are handled through fixed 64-bit carriers, so FIFO_WIDTH and NUM_W
// are limited to 64.
package fifo_pkg;

  localparam int unsigned MaxLanes = 64;
  localparam int unsigned MaxWidth = 64;

  // Value held in unwritten storage and driven on r_data when nothing is readable.
  localparam logic [MaxWidth-1:0] ElemNone = '1;

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  function automatic int unsigned popcount(input logic [MaxLanes-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxLanes; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_nw_compact.sv
// Lane acceptance and compaction: grants the lowest-indexed valid lanes that fit in the free
// space and packs their data into consecutive slots starting at slot 0.
module fifo_nw_compact
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned NUM_W      = 4,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic [NUM_W-1:0]            w_val,
  input  logic [NUM_W*FIFO_WIDTH-1:0] w_data,
  input  logic [CNT_WIDTH-1:0]        free,
  output logic [NUM_W-1:0]            w_rdy,
  output logic [NUM_W*FIFO_WIDTH-1:0] slot_data,
  output logic [CNT_WIDTH-1:0]        n_acc
);

  logic [MaxLanes-1:0]  val_wide;
  logic [MaxLanes-1:0]  rdy_wide;
  logic [MaxLanes-1:0]  low_mask;
  logic [CNT_WIDTH-1:0] pre;

  always_comb begin
    val_wide  = MaxLanes'(w_val);
    w_rdy     = '0;
    slot_data = '1;
    low_mask  = '0;
    pre       = '0;
    for (int i = 0; i < NUM_W; i++) begin
      // Valid lanes below i; an accepted lane lands in that many slots past the tail.
      low_mask = (MaxLanes'(1) << i) - MaxLanes'(1);
      pre      = CNT_WIDTH'(popcount(val_wide & low_mask));
      w_rdy[i] = w_val[i] && (pre < free);
      if (w_rdy[i]) begin
        slot_data[pre*FIFO_WIDTH +: FIFO_WIDTH] = w_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
    rdy_wide = MaxLanes'(w_rdy);
    n_acc    = CNT_WIDTH'(popcount(rdy_wide));
  end

endmodule

// File: rtl/fifo_nw.sv
// Multi-write, single-read first-word-fall-through FIFO with per-lane backpressure.
// Define FIFO_NW_DROP_CNT_EN to add a saturating drop_cnt of refused write lanes.
module fifo_nw
  import fifo_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NUM_W      = 4,
  parameter int unsigned CNT_WIDTH  = clogb2(FIFO_DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_W-1:0]            w_val,
  input  logic [NUM_W*FIFO_WIDTH-1:0] w_data,
  output logic [NUM_W-1:0]            w_rdy,
  input  logic                        r_val,
  output logic [FIFO_WIDTH-1:0]       r_data,
  output logic                        data_avail,
  output logic [CNT_WIDTH-1:0]        size,
  output logic                        full,
  output logic                        empty
`ifdef FIFO_NW_DROP_CNT_EN
  ,
  output logic [15:0]                 drop_cnt
`endif
);

  localparam int unsigned PtrW = clogb2(FIFO_DEPTH);
  localparam logic [FIFO_WIDTH-1:0] ElemNoneW = ElemNone[FIFO_WIDTH-1:0];
  localparam logic [CNT_WIDTH-1:0] DepthC = CNT_WIDTH'(FIFO_DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  size_q, size_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;

  logic [CNT_WIDTH-1:0]        free_eff;
  logic [NUM_W*FIFO_WIDTH-1:0] slot_data;
  logic [CNT_WIDTH-1:0]        n_acc;
  logic                        pop;

  // Free space comes from the registered count only, so a same-cycle pop never
  // opens a lane; zero free space during reset also blocks every lane.
  always_comb begin
    free_eff = rst ? '0 : DepthC - size_q;
  end

  fifo_nw_compact #(
    .FIFO_WIDTH(FIFO_WIDTH),
    .NUM_W     (NUM_W),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_compact (
    .w_val    (w_val),
    .w_data   (w_data),
    .free     (free_eff),
    .w_rdy    (w_rdy),
    .slot_data(slot_data),
    .n_acc    (n_acc)
  );

  always_comb begin
    r_data     = ElemNoneW;
    data_avail = 1'b0;
    if (size_q != '0) begin
      r_data     = mem_q[head_q];
      data_avail = 1'b1;
    end else if (n_acc != '0) begin
      // Empty bypass: slot 0 holds the lowest accepted lane.
      r_data     = slot_data[FIFO_WIDTH-1:0];
      data_avail = 1'b1;
    end
    if (rst) data_avail = 1'b0;
  end

  assign pop = r_val & data_avail;

  // A bypassed word is still written, so head and tail both advance past it.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_W; k++) begin
      if (CNT_WIDTH'(k) < n_acc) begin
        mem_d[tail_q + PtrW'(k)] = slot_data[k*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
    tail_d  = tail_q + n_acc[PtrW-1:0];
    head_d  = head_q + PtrW'(pop);
    size_d  = size_q + n_acc - CNT_WIDTH'(pop);
    full_d  = (size_d == DepthC);
    empty_d = (size_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= ElemNoneW;
      head_q  <= '0;
      tail_q  <= '0;
      size_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      size_q  <= size_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign size  = size_q;
  assign full  = full_q;
  assign empty = empty_q;

`ifdef FIFO_NW_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  logic [16:0] drop_sum;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 17'(popcount(MaxLanes'(w_val & ~w_rdy)));
    drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_fifo_nw.sv
// Scoreboard bench for fifo_nw at FIFO_WIDTH=8, FIFO_DEPTH=8, NUM_W=4.
module tb_fifo_nw;

  logic        clk;
  logic        rst;
  logic [3:0]  w_val;
  logic [31:0] w_data;
  logic [3:0]  w_rdy;
  logic        r_val;
  logic [7:0]  r_data;
  logic        data_avail;
  logic [3:0]  size;
  logic        full;
  logic        empty;
`ifdef FIFO_NW_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int unsigned n_checks;
  int unsigned n_bad;
  logic [7:0]  sb[$];
  int unsigned mdrop;

  fifo_nw #(
    .FIFO_WIDTH(8),
    .FIFO_DEPTH(8),
    .NUM_W     (4),
    .CNT_WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .w_val     (w_val),
    .w_data    (w_data),
    .w_rdy     (w_rdy),
    .r_val     (r_val),
    .r_data    (r_data),
    .data_avail(data_avail),
    .size      (size),
    .full      (full),
    .empty     (empty)
`ifdef FIFO_NW_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check combinational outputs, update scoreboard, check state.
  task automatic step(input logic [3:0] wv, input logic [31:0] wd, input logic rv);
    int unsigned free;
    int unsigned seen;
    logic [3:0]  erdy;
    logic [7:0]  acc[$];
    logic        eav;
    logic [7:0]  erd;
    w_val  = wv;
    w_data = wd;
    r_val  = rv;
    free   = 8 - sb.size();
    seen   = 0;
    erdy   = '0;
    for (int i = 0; i < 4; i++) begin
      if (wv[i]) begin
        if (seen < free) begin
          erdy[i] = 1'b1;
          acc.push_back(wd[i*8 +: 8]);
        end
        seen++;
      end
    end
    if (sb.size() > 0) begin
      eav = 1'b1;
      erd = sb[0];
    end else if (acc.size() > 0) begin
      eav = 1'b1;
      erd = acc[0];
    end else begin
      eav = 1'b0;
      erd = 8'hFF;
    end
    #2;
    check("w_rdy", 32'(w_rdy), 32'(erdy));
    check("data_avail", 32'(data_avail), 32'(eav));
    check("r_data", 32'(r_data), 32'(erd));
    foreach (acc[j]) sb.push_back(acc[j]);
    if (rv && eav) void'(sb.pop_front());
    mdrop += (seen - acc.size());
    if (mdrop > 16'hFFFF) mdrop = 16'hFFFF;
    @(posedge clk);
    #1;
    check("size", 32'(size), sb.size());
    check("full", 32'(full), 32'(sb.size() == 8));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("size_le_depth", 32'(size <= 4'd8), 32'd1);
`ifdef FIFO_NW_DROP_CNT_EN
    check("drop_cnt", 32'(drop_cnt), mdrop);
`endif
  endtask

  task automatic do_reset(input logic [3:0] wv);
    rst    = 1'b1;
    w_val  = wv;
    w_data = 32'hDEADBEEF;
    r_val  = 1'b1;
    #2;
    check("rst_w_rdy", 32'(w_rdy), 32'd0);
    check("rst_avail", 32'(data_avail), 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    mdrop = 0;
    rst   = 1'b0;
    w_val = '0;
    r_val = 1'b0;
    #1;
    check("rst_size", 32'(size), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_r_avail", 32'(data_avail), 32'd0);
    check("rst_r_data", 32'(r_data), 32'hFF);
`ifdef FIFO_NW_DROP_CNT_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    mdrop    = 0;
    rst      = 1'b1;
    w_val    = '0;
    w_data   = '0;
    r_val    = 1'b0;
    @(posedge clk);
    #1;
    do_reset(4'b0000);

    // Two sparse lanes, first visible by bypass, then popped in order.
    step(4'b1010, 32'h33_00_11_00, 1'b0);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b1);
    step(4'b0000, 32'h0, 1'b0);

    // Bypass consumed in the same cycle.
    step(4'b0100, 32'h00_5A_00_00, 1'b1);
    step(4'b0000, 32'h0, 1'b0);

    // Fill to 6, then offer 4 lanes: only two fit.
    step(4'b1111, 32'h04_03_02_01, 1'b0);
    step(4'b0011, 32'h00_00_06_05, 1'b0);
    step(4'b1111, 32'hA3_A2_A1_A0, 1'b0);

    // Full with pop: no lane accepted; space is usable next cycle.
    step(4'b0001, 32'h00_00_00_B0, 1'b1);
    step(4'b0001, 32'h00_00_00_B1, 1'b0);
    for (int i = 0; i < 9; i++) step(4'b0000, 32'h0, 1'b1);

    // Wrap-around traffic mixed with drains.
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 3) step(4'b0000, 32'h0, 1'b1);
      else            step(4'b0111, $urandom(), 1'b1);
    end
    for (int i = 0; i < 10 && sb.size() > 0; i++) step(4'b0000, 32'h0, 1'b1);
    check("drained", sb.size(), 32'd0);

    // Reset mid-stream at size 5.
    step(4'b1111, 32'h14_13_12_11, 1'b0);
    step(4'b0001, 32'h00_00_00_15, 1'b0);
    do_reset(4'b1111);
    step(4'b0001, 32'h00_00_00_77, 1'b1);
    step(4'b0000, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
